// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers with tick strobes and
// shadowed, glitch-free divisor updates. Define CLKDIV_SYNC_EN to enable the i_sync phase-align.

module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 100000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_div_wr,
  input  logic [CH_W-1:0]   i_div_ch,
  input  logic [CNT_W-1:0]  i_div_data,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] wr_data_sat;
  logic             sync;

  // Divisors below 2 cannot produce both a low and a high phase.
  assign wr_data_sat = (i_div_data < MIN_DIV) ? MIN_DIV : i_div_data;

`ifdef CLKDIV_SYNC_EN
  assign sync = i_sync;
`else
  logic sync_unused;
  assign sync        = 1'b0;
  assign sync_unused = i_sync;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] half;
    logic             wr_hit;
    logic             wrap;
    logic             restart;

    assign half   = div_q - (div_q >> 1);
    assign wr_hit = i_div_wr && (i_div_ch == CH_IDX);
    assign wrap   = (cnt_q == div_q - ONE);

    // A new divisor only lands where no period is in flight: at a wrap, a sync, or while idle.
    always_comb begin
      cnt_d    = cnt_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      restart  = !i_en[g] || wrap || sync;

      if (!i_en[g] || sync) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (wrap) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == half - ONE) begin
          clk_d = 1'b1;
        end
      end

      if (restart) begin
        pend_d = 1'b0;
        if (wr_hit) begin
          div_d    = wr_data_sat;
          shadow_d = wr_data_sat;
        end else begin
          div_d = shadow_q;
        end
      end else if (wr_hit) begin
        shadow_d = wr_data_sat;
        pend_d   = 1'b1;
      end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        cnt_q    <= '0;
        div_q    <= RST_DIV;
        shadow_q <= RST_DIV;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        pend_q   <= pend_d;
      end
    end

    assign o_clk[g]     = clk_q;
    assign o_tick[g]    = tick_q;
    assign o_pending[g] = pend_q;
  end

endmodule
